// File: rtl/udp_pixel_framer_if.sv
// Byte-stream and FIFO read-port bundle between the pixel FIFO, the framer and the UDP transmit engine.
// master = framer side, slave = FIFO/transmit side.
interface udp_pixel_framer_if;
  logic        enable;
  logic [10:0] fifo_rnum;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_sop;
  logic        tx_eop;
  logic        tx_ready;
  logic        busy;

  modport master (
    input  enable, fifo_rnum, fifo_rd_data, tx_ready,
    output fifo_rd_en, tx_data, tx_valid, tx_sop, tx_eop, busy
  );

  modport slave (
    output enable, fifo_rnum, fifo_rd_data, tx_ready,
    input  fifo_rd_en, tx_data, tx_valid, tx_sop, tx_eop, busy
  );
endinterface

// File: rtl/udp_pixel_framer.sv
// Frames buffered pixel bytes into packets: 4-byte (frame_id, pkt_id) header, PAYLOAD_BYTES of FIFO
// data through a 2-entry skid buffer, then a forced idle gap.
module udp_pixel_framer #(
  parameter int PAYLOAD_BYTES = 960,
  parameter int FRAME_PKTS    = 160,
  parameter int GAP_CYCLES    = 12
) (
  input  logic               clk,
  input  logic               rst,
  udp_pixel_framer_if.master bus
);

  localparam logic [10:0] PAY_N    = 11'(PAYLOAD_BYTES);
  localparam logic [10:0] PAY_LAST = 11'(PAYLOAD_BYTES - 1);
  localparam logic [15:0] PKT_LAST = 16'(FRAME_PKTS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_GAP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_hdr_idx;
  logic [10:0] r_req_cnt;
  logic [10:0] r_pay_idx;
  logic [15:0] r_gap_cnt;
  logic [15:0] r_frame_id;
  logic [15:0] r_pkt_id;
  logic [1:0]  r_buf_cnt;
  logic        r_inflight;
  logic        r_busy;

  logic [7:0]  w_buf [2];
  logic [7:0]  w_hdr_byte;
  logic [7:0]  w_tx_data;
  logic        w_tx_valid;
  logic        w_tx_sop;
  logic        w_tx_eop;
  logic        w_rd_en;
  logic        w_pop;
  logic        w_hdr_fire;
  logic [1:0]  w_occ;
  logic [1:0]  w_wr_pos;

  always_comb begin
    case (r_hdr_idx)
      2'd0:    w_hdr_byte = r_frame_id[15:8];
      2'd1:    w_hdr_byte = r_frame_id[7:0];
      2'd2:    w_hdr_byte = r_pkt_id[15:8];
      default: w_hdr_byte = r_pkt_id[7:0];
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_valid   = 1'b0;
    w_tx_data    = 8'h00;
    w_tx_sop     = 1'b0;
    w_tx_eop     = 1'b0;
    w_rd_en      = 1'b0;
    w_pop        = 1'b0;
    w_hdr_fire   = 1'b0;
    w_occ        = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (bus.enable && (bus.fifo_rnum >= PAY_N)) w_state_next = S_HDR;
      end
      S_HDR: begin
        w_tx_valid = 1'b1;
        w_tx_data  = w_hdr_byte;
        w_tx_sop   = (r_hdr_idx == 2'd0);
        w_hdr_fire = bus.tx_ready;
        if (bus.tx_ready && (r_hdr_idx == 2'd3)) w_state_next = S_PAY;
      end
      S_PAY: begin
        w_tx_valid = (r_buf_cnt != 2'd0);
        w_tx_data  = w_tx_valid ? w_buf[0] : 8'h00;
        w_tx_eop   = w_tx_valid && (r_pay_idx == PAY_LAST);
        w_pop      = w_tx_valid && bus.tx_ready;
        if (w_pop && (r_pay_idx == PAY_LAST)) w_state_next = S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_next = S_IDLE;
      end
    endcase
    // Occupancy counts the byte leaving this cycle so a new read can replace it: no bubbles at full rate.
    w_occ = r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    if ((r_state == S_HDR || r_state == S_PAY) && (r_req_cnt < PAY_N) && (w_occ < 2'd2))
      w_rd_en = 1'b1;
  end

  assign w_wr_pos = r_buf_cnt - {1'b0, w_pop};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      logic [7:0] r_entry;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_entry <= 8'h00;
        end else if (r_inflight && (w_wr_pos == 2'(gi))) begin
          r_entry <= bus.fifo_rd_data;
        end else if (w_pop && (gi == 0)) begin
          r_entry <= w_buf[1];
        end
      end
      assign w_buf[gi] = r_entry;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hdr_idx  <= 2'd0;
      r_req_cnt  <= 11'd0;
      r_pay_idx  <= 11'd0;
      r_gap_cnt  <= 16'd0;
      r_frame_id <= 16'd0;
      r_pkt_id   <= 16'd0;
      r_buf_cnt  <= 2'd0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_busy     <= (w_state_next != S_IDLE);
      r_inflight <= w_rd_en;
      r_buf_cnt  <= r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      if (r_state == S_IDLE) r_req_cnt <= 11'd0;
      else if (w_rd_en)      r_req_cnt <= r_req_cnt + 11'd1;
      case (r_state)
        S_IDLE: begin
          r_hdr_idx <= 2'd0;
          r_pay_idx <= 11'd0;
          r_gap_cnt <= 16'd0;
          if (!bus.enable) begin
            r_frame_id <= 16'd0;
            r_pkt_id   <= 16'd0;
          end
        end
        S_HDR: begin
          if (w_hdr_fire) r_hdr_idx <= r_hdr_idx + 2'd1;
        end
        S_PAY: begin
          if (w_pop) begin
            r_pay_idx <= r_pay_idx + 11'd1;
            if (r_pay_idx == PAY_LAST) begin
              if (r_pkt_id == PKT_LAST) begin
                r_pkt_id   <= 16'd0;
                r_frame_id <= r_frame_id + 16'd1;
              end else begin
                r_pkt_id <= r_pkt_id + 16'd1;
              end
            end
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt + 16'd1;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.tx_data    = w_tx_data;
  assign bus.tx_valid   = w_tx_valid;
  assign bus.tx_sop     = w_tx_sop;
  assign bus.tx_eop     = w_tx_eop;
  assign bus.busy       = r_busy;

endmodule
